// File: rtl/kband_burst_reader_pkg.sv
// Shared types and elaboration helpers for the KBand burst read master.
package kband_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_ABORTING
  } state_e;

  function automatic int clog2(input int value);
    int result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  // Largest burst the m0 burstcount field can carry.
  function automatic int bmax(input int burst_w);
    return 1 << (burst_w - 1);
  endfunction

endpackage

// File: rtl/kband_burst_reader_fifo.sv
// Show-ahead single-clock FIFO with occupancy count and synchronous flush.
module kband_sc_fifo
  import kband_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             push_data_i,
  input  logic                          pop_i,
  output logic [DATA_W-1:0]             pop_data_o,
  output logic                          valid_o,
  output logic [clog2(DEPTH):0]         count_o
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: sequential state always uses non-blocking assignment so every flop sees pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign valid_o    = (count_q != '0);
  assign pop_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;

  // The credit scheme upstream must never let a push land on a full FIFO.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !pop_i && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/kband_burst_reader.sv
// Avalon-MM burst read master: fetches len_words words from base_addr and streams them out.
module kband_burst_reader
  import kband_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 30,
  parameter int BURST_W    = 5,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_W      = 24
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [LEN_W-1:0]      len_words,
  output logic                  busy,
  output logic                  irq,
  input  logic                  irq_clear,
  input  logic                  m0_waitrequest,
  input  logic [DATA_W-1:0]     m0_readdata,
  input  logic                  m0_readdatavalid,
  output logic [ADDR_W-1:0]     m0_address,
  output logic [BURST_W-1:0]    m0_burstcount,
  output logic                  m0_read,
  output logic [DATA_W/8-1:0]   m0_byteenable,
  output logic [DATA_W-1:0]     src_data,
  output logic                  src_valid,
  input  logic                  src_ready
);

  localparam int BMAX  = bmax(BURST_W);
  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = clog2(FIFO_DEPTH) + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic                m0_read_q, m0_read_d;
  logic [ADDR_W-1:0]   m0_address_q, m0_address_d;
  logic [BURST_W-1:0]  m0_burstcount_q, m0_burstcount_d;
  logic                irq_q, irq_d;

  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    credit;
  logic [BURST_W-1:0]  bcnt;
  logic                accept;
  logic                fifo_push;
  logic                fifo_flush;

  assign accept    = m0_read_q && !m0_waitrequest;
  assign bcnt      = (remaining_q >= LEN_W'(BMAX)) ? BURST_W'(BMAX) : remaining_q[BURST_W-1:0];
  // Words the FIFO can still absorb once everything already requested has landed.
  assign credit    = CNT_W'(FIFO_DEPTH) - fifo_count - outstanding_q;
  assign fifo_push = m0_readdatavalid && (state_q != ST_ABORTING);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    m0_read_d       = m0_read_q;
    m0_address_d    = m0_address_q;
    m0_burstcount_d = m0_burstcount_q;
    irq_d           = irq_q && !irq_clear;
    fifo_flush      = 1'b0;

    outstanding_d = outstanding_q
                  + (accept ? CNT_W'(m0_burstcount_q) : '0)
                  - (m0_readdatavalid ? CNT_W'(1) : '0);

    if (accept) begin
      m0_read_d   = 1'b0;
      addr_d      = addr_q + ADDR_W'(m0_burstcount_q) * ADDR_W'(BYTES);
      remaining_d = remaining_q - LEN_W'(m0_burstcount_q);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (len_words != '0) begin
            state_d     = ST_ISSUE;
            addr_d      = base_addr;
            remaining_d = len_words;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_d = ST_ABORTING;
        end else if (accept && (remaining_d == '0)) begin
          state_d = ST_WAIT;
        end else if (!m0_read_q && (remaining_q != '0) && (credit >= CNT_W'(bcnt))) begin
          m0_read_d       = 1'b1;
          m0_address_d    = addr_q;
          m0_burstcount_d = bcnt;
        end
      end
      ST_WAIT: begin
        if (abort) state_d = ST_ABORTING;
        else if (outstanding_q == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ABORTING: begin
        // A request still on the bus must be accepted and its data drained before flushing.
        if (!m0_read_q && (outstanding_q == '0)) begin
          fifo_flush = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_DONE) irq_d = 1'b1;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      outstanding_q   <= '0;
      m0_read_q       <= 1'b0;
      m0_address_q    <= '0;
      m0_burstcount_q <= '0;
      irq_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      outstanding_q   <= outstanding_d;
      m0_read_q       <= m0_read_d;
      m0_address_q    <= m0_address_d;
      m0_burstcount_q <= m0_burstcount_d;
      irq_q           <= irq_d;
    end
  end

  kband_sc_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_clk),
    .rst_i       (reset_reset),
    .flush_i     (fifo_flush),
    .push_i      (fifo_push),
    .push_data_i (m0_readdata),
    .pop_i       (src_ready),
    .pop_data_o  (src_data),
    .valid_o     (src_valid),
    .count_o     (fifo_count)
  );

  assign busy          = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_ABORTING);
  assign irq           = irq_q;
  assign m0_read       = m0_read_q;
  assign m0_address    = m0_address_q;
  assign m0_burstcount = m0_burstcount_q;
  assign m0_byteenable = {BYTES{m0_read_q}};

endmodule

// File: tb/tb_kband_burst_reader.sv
// Directed bench for kband_burst_reader with a behavioural Avalon-MM memory slave.
module tb_kband_burst_reader;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 30;
  localparam int BURST_W = 5;
  localparam int DEPTH = 32;
  localparam int LEN_W = 24;

  logic                clk = 1'b0;
  logic                reset_reset = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [LEN_W-1:0]    len_words = '0;
  logic                busy, irq;
  logic                irq_clear = 1'b0;
  logic                m0_waitrequest = 1'b0;
  logic [DATA_W-1:0]   m0_readdata = '0;
  logic                m0_readdatavalid = 1'b0;
  logic [ADDR_W-1:0]   m0_address;
  logic [BURST_W-1:0]  m0_burstcount;
  logic                m0_read;
  logic [DATA_W/8-1:0] m0_byteenable;
  logic [DATA_W-1:0]   src_data;
  logic                src_valid;
  logic                src_ready = 1'b1;

  kband_burst_reader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)
  ) dut (
    .clk_clk(clk), .reset_reset(reset_reset), .start(start), .abort(abort),
    .base_addr(base_addr), .len_words(len_words), .busy(busy), .irq(irq), .irq_clear(irq_clear),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid), .m0_address(m0_address),
    .m0_burstcount(m0_burstcount), .m0_read(m0_read), .m0_byteenable(m0_byteenable),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] word_of(input logic [ADDR_W-1:0] a);
    return {a, 2'b01, a, 2'b10, a, 2'b11, ~a, 2'b00};
  endfunction

  // Memory slave / stream monitor state
  logic            wait_force = 1'b0;
  int              rd_budget = 1 << 30;
  logic [ADDR_W-1:0] beats[$];
  logic [ADDR_W-1:0] bl_addr[$];
  int              bl_cnt[$];
  logic [ADDR_W-1:0] exp_base = '0;
  int              acc_cnt = 0;
  int              ret_cnt = 0;
  int              pop_cnt = 0;
  int              max_inflight = 0;
  int              read_cycles = 0;

  // Everything here acts on values that will be seen at the next rising edge.
  always @(negedge clk) begin
    if (reset_reset) begin
      beats.delete();
      m0_readdatavalid = 1'b0;
      m0_readdata      = '0;
      m0_waitrequest   = 1'b0;
    end else begin
      if (src_valid && src_ready) begin
        check("stream_data", src_data, word_of(exp_base + ADDR_W'(pop_cnt) * ADDR_W'(16)));
        pop_cnt++;
      end
      if (beats.size() > 0 && rd_budget > 0) begin
        m0_readdatavalid = 1'b1;
        m0_readdata      = word_of(beats.pop_front());
        rd_budget--;
        ret_cnt++;
      end else begin
        m0_readdatavalid = 1'b0;
        m0_readdata      = '0;
      end
      m0_waitrequest = wait_force;
      if (m0_read) read_cycles++;
      if (m0_read && !wait_force) begin
        check("byteenable", m0_byteenable, {(DATA_W/8){1'b1}});
        bl_addr.push_back(m0_address);
        bl_cnt.push_back(int'(m0_burstcount));
        for (int k = 0; k < int'(m0_burstcount); k++)
          beats.push_back(m0_address + ADDR_W'(k) * ADDR_W'(16));
        acc_cnt += int'(m0_burstcount);
      end
      if (acc_cnt - pop_cnt > max_inflight) max_inflight = acc_cnt - pop_cnt;
    end
  end

  typedef struct {
    logic [ADDR_W-1:0] base;
    int                len;
    int                nbursts;
    int                first_bc;
    int                last_bc;
    logic [ADDR_W-1:0] last_addr;
  } vec_t;

  vec_t vecs[5];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [ADDR_W-1:0] b, input int len);
    exp_base = b;
    pop_cnt = 0; acc_cnt = 0; ret_cnt = 0; max_inflight = 0;
    bl_addr.delete(); bl_cnt.delete();
    base_addr = b;
    len_words = LEN_W'(len);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_irq(input int limit);
    int n = 0;
    while (!irq && n < limit) begin step(1); n++; end
    check("irq_timeout", irq, 1'b1);
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (src_valid && n < limit) begin step(1); n++; end
    check("drain_timeout", src_valid, 1'b0);
  endtask

  task automatic clear_irq();
    irq_clear = 1'b1;
    step(1);
    irq_clear = 1'b0;
    check("irq_cleared", irq, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    start_xfer(v.base, v.len);
    check("busy_after_start", busy, 1'b1);
    wait_irq(3000);
    check("beats_before_irq", ret_cnt, v.len);
    wait_drain(500);
    check("words_streamed", pop_cnt, v.len);
    check("n_bursts", bl_cnt.size(), v.nbursts);
    check("first_addr", bl_addr[0], v.base);
    check("first_bc", bl_cnt[0], v.first_bc);
    check("last_bc", bl_cnt[bl_cnt.size()-1], v.last_bc);
    check("last_addr", bl_addr[bl_addr.size()-1], v.last_addr);
    check("busy_idle", busy, 1'b0);
    check("irq_sticky", irq, 1'b1);
    clear_irq();
  endtask

  initial begin
    int n;
    vecs[0] = '{30'h0000_1000, 20, 2, 16, 4,  30'h0000_1100};
    vecs[1] = '{30'h0000_2000, 16, 1, 16, 16, 30'h0000_2000};
    vecs[2] = '{30'h0000_0040, 1,  1, 1,  1,  30'h0000_0040};
    vecs[3] = '{30'h3FFF_FFF0, 17, 2, 16, 1,  30'h0000_00F0};
    vecs[4] = '{30'h0000_0500, 33, 3, 16, 1,  30'h0000_0700};

    // Reset state
    #2 reset_reset = 1'b1;
    step(3);
    check("rst_m0_read", m0_read, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_src_valid", src_valid, 1'b0);
    check("rst_src_data", src_data, '0);
    check("rst_byteenable", m0_byteenable, '0);
    check("rst_burstcount", m0_burstcount, '0);
    check("rst_address", m0_address, '0);
    reset_reset = 1'b0;
    step(2);

    // Table-driven transfers, including a tail burst and address wrap
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Zero-length start: straight to done, irq set beats a simultaneous clear
    read_cycles = 0;
    base_addr = '0;
    len_words = '0;
    start = 1'b1;
    irq_clear = 1'b1;
    step(1);
    start = 1'b0;
    irq_clear = 1'b0;
    check("len0_irq", irq, 1'b1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy) n++;
      step(1);
    end
    check("len0_busy_cycles", n, 0);
    check("len0_reads", read_cycles, 0);
    check("len0_irq_sticky", irq, 1'b1);
    clear_irq();

    // Stream stalled: credits limit requests to the FIFO depth
    src_ready = 1'b0;
    start_xfer(30'h0001_0000, 100);
    step(150);
    check("stall_requested", acc_cnt, 32);
    check("stall_m0_read", m0_read, 1'b0);
    check("stall_src_valid", src_valid, 1'b1);
    check("stall_src_data", src_data, word_of(30'h0001_0000));
    src_ready = 1'b1;
    wait_irq(3000);
    wait_drain(500);
    check("stall_words", pop_cnt, 100);
    check("stall_max_inflight", max_inflight, 32);
    clear_irq();

    // Held request under waitrequest; start while busy is ignored
    wait_force = 1'b1;
    start_xfer(30'h0000_8000, 20);
    n = 0;
    while (!m0_read && n < 20) begin step(1); n++; end
    check("wr_read_seen", m0_read, 1'b1);
    base_addr = 30'h0000_9990;
    len_words = 24'd3;
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("wr_read_held", m0_read, 1'b1);
      check("wr_addr_held", m0_address, 30'h0000_8000);
      check("wr_bc_held", m0_burstcount, 5'd16);
      step(1);
    end
    wait_force = 1'b0;
    wait_irq(3000);
    wait_drain(500);
    check("wr_words", pop_cnt, 20);
    check("wr_n_bursts", bl_cnt.size(), 2);
    check("wr_second_addr", bl_addr[1], 30'h0000_8100);
    clear_irq();

    // Abort with ten words still outstanding and six parked in the FIFO
    src_ready = 1'b0;
    rd_budget = 6;
    start_xfer(30'h0000_4000, 16);
    n = 0;
    while ((ret_cnt < 6 || acc_cnt < 16) && n < 100) begin step(1); n++; end
    step(3);
    check("ab_pre_ret", ret_cnt, 6);
    check("ab_pre_valid", src_valid, 1'b1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("ab_busy_held", busy, 1'b1);
    rd_budget = 1 << 30;
    n = 0;
    while (busy && n < 100) begin step(1); n++; end
    check("ab_busy_drop", busy, 1'b0);
    check("ab_all_returned", ret_cnt, 16);
    check("ab_no_new_req", acc_cnt, 16);
    step(4);
    check("ab_flushed", src_valid, 1'b0);
    check("ab_irq", irq, 1'b0);
    check("ab_popped", pop_cnt, 0);
    src_ready = 1'b1;

    // Asynchronous reset mid-transfer, then a normal transfer
    start_xfer(30'h0000_0100, 100);
    step(15);
    check("rs_busy_before", busy, 1'b1);
    #2 reset_reset = 1'b1;
    #1;
    check("rs_busy", busy, 1'b0);
    check("rs_m0_read", m0_read, 1'b0);
    check("rs_src_valid", src_valid, 1'b0);
    check("rs_burstcount", m0_burstcount, '0);
    check("rs_irq", irq, 1'b0);
    step(2);
    reset_reset = 1'b0;
    step(2);
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
